// File: rtl/aes_v1_round_seq_if.sv
// Signal bundle between the AES round sequencer, its requester, the 32-bit
// SubBytes/MixColumns unit and the result consumer. dbg_state mirrors the sequencer FSM.
interface aes_v1_round_seq_if;
    // Every handshake here (in, req/rsp, out) transfers on a rising edge where
    // valid and ready are both high; a source holds its payload stable until then.
    logic         in_valid;
    logic         in_ready;
    logic         in_dec;
    logic         in_final;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         req_valid;
    logic         req_dec;
    logic         req_mix;
    logic [31:0]  req_rs1;
    logic         rsp_ready;
    logic [31:0]  rsp_rd;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;
    logic [1:0]   dbg_state;

    modport master (
        output in_valid, in_dec, in_final, in_state, in_key,
        output rsp_ready, rsp_rd, out_ready,
        input  in_ready, req_valid, req_dec, req_mix, req_rs1,
        input  out_valid, out_state, busy, dbg_state
    );

    modport slave (
        input  in_valid, in_dec, in_final, in_state, in_key,
        input  rsp_ready, rsp_rd, out_ready,
        output in_ready, req_valid, req_dec, req_mix, req_rs1,
        output out_valid, out_state, busy, dbg_state
    );
endinterface

// File: rtl/aes_v1_round_seq.sv
// One AES round (encrypt, or decrypt when AES_ROUND_SEQ_DECRYPT_EN is defined) sequenced
// over an external 32-bit SubBytes/MixColumns unit; ShiftRows and AddRoundKey are local.
module aes_v1_round_seq #(
    parameter int NWORDS = 4
) (
    input  logic              g_clk,
    input  logic              g_reset,
    aes_v1_round_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] LAST_COL = 2'(NWORDS - 1);

    state_e       fsm_q, fsm_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] st_q, st_d;
    logic [127:0] key_q, key_d;
    logic [127:0] out_q, out_d;
    logic         dec_q, dec_d;
    logic         fin_q, fin_d;

    logic [127:0] st_w;
    logic [127:0] sr_w;

    // Row r of column c takes row r of column (c+r) mod 4.
    function automatic logic [127:0] shift_rows_enc(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[32*c + 8*rr +: 8] = s[32*((c + rr) % 4) + 8*rr +: 8];
            end
        end
        return r;
    endfunction

`ifdef AES_ROUND_SEQ_DECRYPT_EN
    // Row r of column c takes row r of column (c-r) mod 4.
    function automatic logic [127:0] shift_rows_dec(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[32*c + 8*rr +: 8] = s[32*((c + 4 - rr) % 4) + 8*rr +: 8];
            end
        end
        return r;
    endfunction
`else
    logic unused_in_dec;
    assign unused_in_dec = bus.in_dec;
`endif

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            fsm_q <= IDLE;
            col_q <= 2'd0;
            st_q  <= '0;
            key_q <= '0;
            out_q <= '0;
            dec_q <= 1'b0;
            fin_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            col_q <= col_d;
            st_q  <= st_d;
            key_q <= key_d;
            out_q <= out_d;
            dec_q <= dec_d;
            fin_q <= fin_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        col_d = col_q;
        st_d  = st_q;
        key_d = key_q;
        out_d = out_q;
        dec_d = dec_q;
        fin_d = fin_q;

        // Working copy with the unit's answer dropped into the current column.
        st_w = st_q;
        st_w[32*col_q +: 32] = bus.rsp_rd;

        // End-of-SubBytes transform: ShiftRows plus any key XOR due at this edge.
`ifdef AES_ROUND_SEQ_DECRYPT_EN
        sr_w = dec_q ? shift_rows_dec(st_w) : shift_rows_enc(st_w);
        if (dec_q || fin_q) begin
            sr_w = sr_w ^ key_q;
        end
`else
        sr_w = shift_rows_enc(st_w);
        if (fin_q) begin
            sr_w = sr_w ^ key_q;
        end
`endif

        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d  = bus.in_state;
                    key_d = bus.in_key;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
                    dec_d = bus.in_dec;
`else
                    dec_d = 1'b0;
`endif
                    fin_d = bus.in_final;
                    col_d = 2'd0;
                    fsm_d = SUB;
                end
            end
            SUB: begin
                if (bus.rsp_ready) begin
                    if (col_q == LAST_COL) begin
                        col_d = 2'd0;
                        st_d  = sr_w;
                        if (fin_q) begin
                            out_d = sr_w;
                            fsm_d = DONE;
                        end else begin
                            fsm_d = MIX;
                        end
                    end else begin
                        st_d  = st_w;
                        col_d = col_q + 2'd1;
                    end
                end
            end
            MIX: begin
                if (bus.rsp_ready) begin
                    if (col_q == LAST_COL) begin
                        col_d = 2'd0;
`ifdef AES_ROUND_SEQ_DECRYPT_EN
                        st_d  = dec_q ? st_w : (st_w ^ key_q);
`else
                        st_d  = st_w ^ key_q;
`endif
                        out_d = st_d;
                        fsm_d = DONE;
                    end else begin
                        st_d  = st_w;
                        col_d = col_q + 2'd1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    col_d = 2'd0;
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
                col_d = 2'd0;
            end
        endcase
    end

    // Request fields come straight from registers, so they stay put while the unit stalls.
    always_comb begin
        bus.in_ready  = (fsm_q == IDLE);
        bus.busy      = (fsm_q != IDLE);
        bus.req_valid = (fsm_q == SUB) || (fsm_q == MIX);
        bus.req_mix   = (fsm_q == MIX);
        bus.req_dec   = bus.req_valid & dec_q;
        bus.req_rs1   = bus.req_valid ? st_q[32*col_q +: 32] : 32'd0;
        bus.out_valid = (fsm_q == DONE);
        bus.out_state = out_q;
        bus.dbg_state = fsm_q;
    end

endmodule

// File: tb/tb_aes_v1_round_seq.sv
// Self-checking bench for aes_v1_round_seq: behavioural SubBytes/MixColumns unit plus an
// AES round reference model built from GF(2^8) arithmetic.
module tb_aes_v1_round_seq;

    logic g_clk = 1'b0;
    logic g_reset = 1'b1;
    always #5 g_clk = ~g_clk;

    aes_v1_round_seq_if bus();

    aes_v1_round_seq #(.NWORDS(4)) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (bus)
    );

`ifdef AES_ROUND_SEQ_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    // ---------------- AES primitives ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] g;
        g = ginv(x);
        return g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a[4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = w[8*i +: 8];
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = gmul(a[i], 8'h02) ^ gmul(a[(i+1)%4], 8'h03) ^ a[(i+2)%4] ^ a[(i+3)%4];
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a[4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = w[8*i +: 8];
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = gmul(a[i], 8'h0e) ^ gmul(a[(i+1)%4], 8'h0b) ^
                          gmul(a[(i+2)%4], 8'h0d) ^ gmul(a[(i+3)%4], 8'h09);
        return r;
    endfunction

    // One round on a 4x4 byte matrix s[column][row], following the AES round definitions.
    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic dec, input logic fin);
        logic [7:0] s[4][4];
        logic [7:0] t[4][4];
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                s[c][rr] = dec ? inv_sbox(st[32*c + 8*rr +: 8]) : sbox(st[32*c + 8*rr +: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[c][rr] = dec ? s[(c + 4 - rr) % 4][rr] : s[(c + rr) % 4][rr];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                r[32*c + 8*rr +: 8] = t[c][rr];
        if (dec) begin
            r = r ^ key;
            if (!fin) for (int c = 0; c < 4; c++) r[32*c +: 32] = inv_mix_col(r[32*c +: 32]);
        end else begin
            if (!fin) for (int c = 0; c < 4; c++) r[32*c +: 32] = mix_col(r[32*c +: 32]);
            r = r ^ key;
        end
        return r;
    endfunction

    // FIPS hex strings list byte0 first; the port puts byte0 in bits [7:0].
    function automatic logic [127:0] bswap128(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127 - 8*i -: 8];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- behavioural single-cycle unit ----------------
    logic [31:0] unit_rd;
    always_comb begin
        unit_rd = 32'd0;
        if (bus.req_mix) begin
            unit_rd = bus.req_dec ? inv_mix_col(bus.req_rs1) : mix_col(bus.req_rs1);
        end else begin
            for (int b = 0; b < 4; b++)
                unit_rd[8*b +: 8] = bus.req_dec ? inv_sbox(bus.req_rs1[8*b +: 8])
                                                : sbox(bus.req_rs1[8*b +: 8]);
        end
    end
    assign bus.rsp_rd = unit_rd;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_in_ready"},  bus.in_ready,  1);
        chk({p, "_req_valid"}, bus.req_valid, 0);
        chk({p, "_req_dec"},   bus.req_dec,   0);
        chk({p, "_req_mix"},   bus.req_mix,   0);
        chk({p, "_req_rs1"},   bus.req_rs1,   0);
        chk({p, "_out_valid"}, bus.out_valid, 0);
        chk({p, "_out_state"}, bus.out_state, 0);
        chk({p, "_busy"},      bus.busy,      0);
    endtask

    // stall_mode: 0 = unit always ready, 1 = random stalls, 2 = 3-cycle stall at SUB column 2.
    task automatic run_round(input logic [127:0] st, input logic [127:0] key,
                             input logic dec, input logic fin, input int stall_mode,
                             input int hold, input bit junk, output int lat);
        int cycles, reqs, sub_hs, mix_hs, stalls, dec_bad, stable_bad, inrdy_bad, held_bad;
        int stall_left;
        bit stalled_once, prev_stall, rdy;
        logic [33:0] prev_req;
        logic [127:0] snap, exp;
        logic eff_dec;
        eff_dec = dec & DEC_EN;
        exp_q.push_back(ref_round(st, key, eff_dec, fin));
        cycles = 0; reqs = 0; sub_hs = 0; mix_hs = 0; stalls = 0; dec_bad = 0;
        stable_bad = 0; inrdy_bad = 0; held_bad = 0; stall_left = 0;
        stalled_once = 0; prev_stall = 0; prev_req = '0;

        bus.in_state = st; bus.in_key = key; bus.in_dec = dec; bus.in_final = fin;
        bus.in_valid = 1'b1; bus.rsp_ready = 1'b1; bus.out_ready = 1'b0;
        chk("accept_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = junk;
        if (junk) begin
            bus.in_state = rand128(); bus.in_key = rand128();
            bus.in_dec = 1'($urandom_range(0, 1)); bus.in_final = 1'($urandom_range(0, 1));
        end

        while (bus.out_valid !== 1'b1 && cycles < 200) begin
            if (bus.in_ready !== 1'b0) inrdy_bad++;
            if (prev_stall && {bus.req_rs1, bus.req_mix, bus.req_dec} !== prev_req) stable_bad++;
            rdy = 1'b1;
            if (stall_mode == 1 && $urandom_range(0, 3) == 0) rdy = 1'b0;
            if (stall_mode == 2) begin
                if (stall_left == 0 && !stalled_once && bus.req_valid === 1'b1 &&
                    bus.req_mix === 1'b0 && sub_hs == 2) begin
                    stall_left = 3;
                    stalled_once = 1'b1;
                end
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end
            end
            bus.rsp_ready = rdy;
            if (bus.req_valid === 1'b1) begin
                reqs++;
                if (bus.req_dec !== eff_dec) dec_bad++;
                if (rdy) begin
                    if (bus.req_mix === 1'b1) mix_hs++; else sub_hs++;
                end else begin
                    stalls++;
                end
            end
            prev_stall = (bus.req_valid === 1'b1) && !rdy;
            prev_req = {bus.req_rs1, bus.req_mix, bus.req_dec};
            tick();
            cycles++;
        end
        bus.rsp_ready = 1'b1;
        lat = cycles;

        chk("done_reached", bus.out_valid, 1);
        chk("latency", cycles, (fin ? 4 : 8) + stalls);
        chk("req_cycles", reqs, (fin ? 4 : 8) + stalls);
        chk("sub_words", sub_hs, 4);
        chk("mix_words", mix_hs, fin ? 0 : 4);
        chk("req_dec_each", dec_bad, 0);
        chk("req_stable_stall", stable_bad, 0);
        chk("in_ready_busy", inrdy_bad, 0);
        exp = exp_q.pop_front();
        chk("out_state", bus.out_state, exp);

        snap = bus.out_state;
        repeat (hold) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_state !== snap ||
                bus.in_ready !== 1'b0 || bus.busy !== 1'b1) held_bad++;
        end
        if (hold > 0) chk("out_hold", held_bad, 0);

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("out_valid_drop", bus.out_valid, 0);
        chk("in_ready_back", bus.in_ready, 1);
        chk("out_state_keep", bus.out_state, snap);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat, n, mixhs, ov_bad;
        logic [127:0] fips_in, fips_key, fips_out, s, k;
        fips_in  = bswap128(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        fips_key = bswap128(128'ha0fafe1788542cb123a339392a6c7605);
        fips_out = bswap128(128'ha49c7ff2689f352b6b5bea43026a5049);

        bus.in_valid = 1'b0; bus.in_dec = 1'b0; bus.in_final = 1'b0;
        bus.in_state = '0; bus.in_key = '0; bus.rsp_ready = 1'b1; bus.out_ready = 1'b0;
        g_reset = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        g_reset = 1'b0;
        tick();

        // FIPS-197 round 1 encrypt
        run_round(fips_in, fips_key, 1'b0, 1'b0, 0, 0, 1'b0, lat);
        chk("fips_latency", lat, 8);
        chk("fips_out_const", bus.out_state, fips_out);

        // Final encrypt of zeros -> 0x63 bytes
        run_round('0, '0, 1'b0, 1'b1, 0, 0, 1'b0, lat);
        chk("enc_final_latency", lat, 4);
        chk("enc_final_63", bus.out_state, {16{8'h63}});

        // Final decrypt of zeros -> 0x52 bytes (encrypt behaviour when decrypt is compiled out)
        run_round('0, '0, 1'b1, 1'b1, 0, 0, 1'b0, lat);
        chk("dec_final_const", bus.out_state, DEC_EN ? {16{8'h52}} : {16{8'h63}});

        // Non-final decrypt of the FIPS round output with the same key
        run_round(fips_out, fips_key, 1'b1, 1'b0, 0, 0, 1'b0, lat);

        // Unit backpressure at SUB column 2 plus consumer backpressure for 5 cycles
        run_round(rand128(), rand128(), 1'b0, 1'b0, 2, 5, 1'b0, lat);
        chk("bp_latency", lat, 11);

        // Reset while the MIX pass is on column 1
        bus.in_state = fips_in; bus.in_key = fips_key; bus.in_dec = 1'b0; bus.in_final = 1'b0;
        bus.in_valid = 1'b1; bus.rsp_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0; mixhs = 0;
        while (!(bus.req_valid === 1'b1 && bus.req_mix === 1'b1 && mixhs == 1) && n < 50) begin
            if (bus.req_valid === 1'b1 && bus.req_mix === 1'b1) mixhs++;
            tick();
            n++;
        end
        chk("rst_at_mix_col1", {bus.req_valid, bus.req_mix}, 2'b11);
        g_reset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        g_reset = 1'b0;
        ov_bad = 0;
        repeat (12) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) ov_bad++;
        end
        chk("midrst_no_out", ov_bad, 0);
        run_round(fips_in, fips_key, 1'b0, 1'b0, 0, 0, 1'b1, lat);
        chk("after_rst_fips", bus.out_state, fips_out);

        // Randomised rounds with random unit stalls, consumer holds and junk requests
        for (int i = 0; i < 24; i++) begin
            s = rand128();
            k = rand128();
            run_round(s, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1,
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
